input_interface: RTL and testbench

Byte-serial front end of the AES engine. Accepts the 128-bit key and 128-bit plaintext one byte per cycle over a valid/ready handshake and assembles them MSB-first. It then issues a one-cycle start pulse to the transformer and holds both words stable until `transformer_done`. It is the mirror of `output_interface`, which sits on the transformer's other side.

---
 rtl/input_interface.sv | 128 ++++++++++++
 tb/tb_input_interface.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/input_interface.sv
// Byte-serial AES input front end: assembles key and plaintext MSB-first, pulses start, holds words until done.
// Optional key reuse across blocks is enabled by defining KEY_REUSE_EN.
module input_interface (
  input  logic         clk,
  input  logic         rst_,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  output logic         in_ready,
  input  logic         new_key,
  input  logic         transformer_done,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         transformer_start,
  output logic         busy
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LAST_BYTE = BLOCK_W / BYTE_W - 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_TEXT = 3'd2,
    START     = 3'd3,
    BUSY      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0]   text_q, text_d;
  logic                 ready_q, ready_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 reload_c;
  logic                 xfer_c;

`ifdef KEY_REUSE_EN
  // Key reload request at a block boundary pre-empts any byte offered the same cycle.
  assign reload_c = new_key && (state_q == LOAD_TEXT) && (cnt_q == '0);
`else
  logic unused_new_key;
  assign unused_new_key = new_key;
  assign reload_c       = 1'b0;
`endif

  assign in_ready = ready_q & ~reload_c;
  assign xfer_c   = data_valid & in_ready;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      text_q  <= text_d;
      ready_q <= ready_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    text_d  = text_q;
    ready_d = 1'b0;
    start_d = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: state_d = LOAD_KEY;

      LOAD_KEY: begin
        if (xfer_c) begin
          key_d = {key_q[BLOCK_W-BYTE_W-1:0], data_in};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_BYTE)) state_d = LOAD_TEXT;
        end
      end

      LOAD_TEXT: begin
        if (reload_c) begin
          state_d = LOAD_KEY;
        end else if (xfer_c) begin
          text_d = {text_q[BLOCK_W-BYTE_W-1:0], data_in};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_BYTE)) state_d = START;
        end
      end

      START: state_d = BUSY;

      BUSY: begin
        if (transformer_done) begin
`ifdef KEY_REUSE_EN
          state_d = new_key ? LOAD_KEY : LOAD_TEXT;
`else
          state_d = LOAD_KEY;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // Output flags track the state being entered so they are registered alongside it.
    ready_d = (state_d == LOAD_KEY) || (state_d == LOAD_TEXT);
    start_d = (state_d == START);
    busy_d  = (state_d == BUSY);
  end

  assign key               = key_q;
  assign plaintext         = text_q;
  assign transformer_start = start_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_input_interface.sv
// Directed self-checking bench for input_interface; covers the key-reuse path when KEY_REUSE_EN is defined.
module tb_input_interface;

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic [7:0]   data_in = 8'h00;
  logic         data_valid = 1'b0;
  logic         in_ready;
  logic         new_key = 1'b0;
  logic         transformer_done = 1'b0;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         transformer_start;
  logic         busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KEY_V = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_V  = 128'h3243F6A8885A308D313198A2E0370734;

  logic [7:0] kb [16] = '{8'h2B, 8'h7E, 8'h15, 8'h16, 8'h28, 8'hAE, 8'hD2, 8'hA6,
                          8'hAB, 8'hF7, 8'h15, 8'h88, 8'h09, 8'hCF, 8'h4F, 8'h3C};
  logic [7:0] pb [16] = '{8'h32, 8'h43, 8'hF6, 8'hA8, 8'h88, 8'h5A, 8'h30, 8'h8D,
                          8'h31, 8'h31, 8'h98, 8'hA2, 8'hE0, 8'h37, 8'h07, 8'h34};

  input_interface dut (
    .clk               (clk),
    .rst_              (rst_),
    .data_in           (data_in),
    .data_valid        (data_valid),
    .in_ready          (in_ready),
    .new_key           (new_key),
    .transformer_done  (transformer_done),
    .key               (key),
    .plaintext         (plaintext),
    .transformer_start (transformer_start),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for a single cycle; inputs change 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    data_valid = 1'b1;
    data_in    = b;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_key", key, 128'h0);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_start", 128'(transformer_start), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));

    rst_ = 1'b0;
    #2;
    chk("ready_before_first_edge", 128'(in_ready), 128'(0));
    tick();
    chk("ready_after_first_edge", 128'(in_ready), 128'(1));

    // Back-to-back 32-byte stream
    for (int i = 0; i < 16; i++) send(kb[i]);
    chk("key_done_text_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 15; i++) send(pb[i]);
    chk("no_start_at_31", 128'(transformer_start), 128'(0));
    send(pb[15]);
    chk("start_pulse", 128'(transformer_start), 128'(1));
    chk("start_ready_low", 128'(in_ready), 128'(0));
    chk("key_word", key, KEY_V);
    chk("plaintext_word", plaintext, PT_V);
    tick();
    chk("start_single_cycle", 128'(transformer_start), 128'(0));
    chk("busy_set", 128'(busy), 128'(1));

    // Bytes offered while busy must be refused
    for (int i = 0; i < 10; i++) begin
      data_valid = 1'b1;
      data_in    = 8'hFF;
      chk("busy_ready_low", 128'(in_ready), 128'(0));
      tick();
    end
    data_valid = 1'b0;
    chk("busy_key_hold", key, KEY_V);
    chk("busy_text_hold", plaintext, PT_V);
    chk("busy_still", 128'(busy), 128'(1));
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    chk("done_ready_back", 128'(in_ready), 128'(1));
    chk("done_busy_clear", 128'(busy), 128'(0));

`ifdef KEY_REUSE_EN
    // Reused key: only 16 plaintext bytes needed
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("reuse_start", 128'(transformer_start), 128'(1));
    chk("reuse_key_kept", key, KEY_V);
    chk("reuse_plaintext", plaintext, 128'h000102030405060708090A0B0C0D0E0F);
    tick();
    transformer_done = 1'b1;
    new_key = 1'b1;
    tick();
    transformer_done = 1'b0;
    new_key = 1'b0;
    // 16 bytes now land in the key; no start yet
    for (int i = 0; i < 16; i++) send(kb[i]);
    chk("newkey_no_start_16", 128'(transformer_start), 128'(0));
    chk("newkey_key_reloaded", key, KEY_V);
    chk("newkey_text_untouched", plaintext, 128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 16; i++) send(pb[i]);
    chk("newkey_start_32", 128'(transformer_start), 128'(1));
    chk("newkey_plaintext", plaintext, PT_V);
    tick();
    transformer_done = 1'b1;
    new_key = 1'b1;
    tick();
    transformer_done = 1'b0;
    new_key = 1'b0;
`endif

    // Same stream with a one-cycle gap between bytes
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      send(i < 16 ? kb[i] : pb[i-16]);
      if (i == 30) chk("gap_no_early_start", 128'(transformer_start), 128'(0));
    end
    chk("gap_start", 128'(transformer_start), 128'(1));
    chk("gap_key", key, KEY_V);
    chk("gap_plaintext", plaintext, PT_V);
    tick();
    chk("gap_busy", 128'(busy), 128'(1));

    // Asynchronous reset mid-busy
    #2;
    rst_ = 1'b1;
    #1;
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_key", key, 128'h0);
    tick();
    rst_ = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send(8'hA5);
    chk("partial_key", key, 128'h0000000000000000000000A5A5A5A5A5A5A5);
    // Asynchronous reset mid-load
    #2;
    rst_ = 1'b1;
    #1;
    chk("async_rst_ready", 128'(in_ready), 128'(0));
    chk("async_rst_partial", key, 128'h0);
    tick();
    rst_ = 1'b0;
    tick();

    // Done pulse in LOAD_KEY is ignored
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    chk("done_in_load_ready", 128'(in_ready), 128'(1));
    chk("done_in_load_start", 128'(transformer_start), 128'(0));
    chk("done_in_load_busy", 128'(busy), 128'(0));

    // Fresh stream with words swapped: key must hold only post-reset bytes
    for (int i = 0; i < 16; i++) send(pb[i]);
    for (int i = 0; i < 16; i++) send(kb[i]);
    chk("post_rst_start", 128'(transformer_start), 128'(1));
    chk("post_rst_key", key, PT_V);
    chk("post_rst_plaintext", plaintext, KEY_V);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
